keypad_fifo_ctrl: RTL and testbench

Sequencing controller between the keypad scanner and the bird CPU bus. It autonomously polls the keypad status and reads each key code. It acknowledges the keypad and buffers codes in a small FIFO. The CPU reads them through two memory-mapped registers (data at BASE, status at BASE+1) and no longer drives the keypad handshake directly.

---
 rtl/keypad_fifo_ctrl.sv | 136 +++++++++++++
 tb/tb_keypad_fifo_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_fifo_ctrl.sv
// Keypad scanner sequencer with a small code FIFO behind two CPU registers (data at BASE, status at BASE+1).
// Optional KPFIFO_OVERFLOW_DROP_EN: keep polling when full, drop the code and set a sticky overflow flag.
module keypad_fifo_ctrl #(
    parameter logic [11:0] BASE     = 12'h900,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter int          POLL_GAP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] address,
    input  logic        mem_wrt,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] rd_data,
    output logic        sel,
    input  logic [3:0]  kp_keyout,
    output logic        kp_statusordata,
    output logic        kp_ack
);
    localparam int             CW        = PTR_W + 1;
    localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
    localparam logic [11:0]    STAT_ADDR = BASE + 12'd1;
    localparam int             GAP_W     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    typedef enum logic [2:0] {IDLE, STAT, DATA, PUSH, GAP} state_t;

    state_t             state, state_n;
    logic [GAP_W-1:0]   gap_cnt;
    logic [3:0]         code_q;
    logic [3:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               prev_addr_hit;
    logic               push_req, push_ok, pop, flush;
    logic               full, not_empty, hit_data, hit_stat, ovf;
    logic               unused_wdata;

    assign unused_wdata = ^cpu_wdata[15:1];

    assign full      = (count == FULL_CNT);
    assign not_empty = (count != '0);
    assign hit_data  = (address == BASE);
    assign hit_stat  = (address == STAT_ADDR);
    assign sel       = hit_data | hit_stat;

    // Only the first cycle of a BASE access pops, so stretched reads consume one entry.
    assign pop     = hit_data & ~prev_addr_hit & ~mem_wrt & not_empty;
    assign flush   = hit_stat & mem_wrt & cpu_wdata[0];
    assign push_ok = push_req & (~full | pop);

    always_comb begin
        state_n         = state;
        kp_statusordata = 1'b0;
        kp_ack          = 1'b0;
        push_req        = 1'b0;
        case (state)
            IDLE: begin
`ifdef KPFIFO_OVERFLOW_DROP_EN
                state_n = STAT;
`else
                if (!full) state_n = STAT;
`endif
            end
            STAT: begin
                kp_statusordata = 1'b1;
                state_n = kp_keyout[0] ? DATA : IDLE;
            end
            DATA: state_n = PUSH;
            PUSH: begin
                kp_ack   = 1'b1;
                push_req = 1'b1;
                state_n  = GAP;
            end
            GAP:  if (gap_cnt == GAP_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            code_q        <= '0;
            prev_addr_hit <= 1'b0;
        end else begin
            state         <= state_n;
            prev_addr_hit <= hit_data;
            if (state == DATA) code_q <= kp_keyout;
            if (state == GAP && gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + GAP_W'(1);
            else                                     gap_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= code_q;
    end

`ifdef KPFIFO_OVERFLOW_DROP_EN
    logic ovf_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      ovf_q <= 1'b0;
        else if (flush)                 ovf_q <= 1'b0;
        else if (push_req && !push_ok)  ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_comb begin
        rd_data = 16'h0000;
        if (hit_data && not_empty) rd_data = {12'h000, mem[rd_ptr]};
        else if (hit_stat)         rd_data = {ovf, 10'b0, 3'(count), full, not_empty};
    end
endmodule

// File: tb/tb_keypad_fifo_ctrl.sv
// Directed bench for keypad_fifo_ctrl with a queue-based keypad model; KPFIFO_OVERFLOW_DROP_EN selects the overflow expectations.
module tb_keypad_fifo_ctrl;
    localparam logic [11:0] BASE  = 12'h900;
    localparam logic [11:0] SADDR = 12'h901;
`ifdef KPFIFO_OVERFLOW_DROP_EN
    localparam int FILL = 4;
`else
    localparam int FILL = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] address;
    logic        mem_wrt;
    logic [15:0] cpu_wdata;
    logic [15:0] rd_data;
    logic        sel;
    logic [3:0]  kp_keyout;
    logic        kp_statusordata;
    logic        kp_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] kq [0:15];
    int kq_tail = 0;
    int kq_head = 0;
    int ack_cnt = 0;

    keypad_fifo_ctrl dut (
        .clk(clk), .reset(reset), .address(address), .mem_wrt(mem_wrt),
        .cpu_wdata(cpu_wdata), .rd_data(rd_data), .sel(sel),
        .kp_keyout(kp_keyout), .kp_statusordata(kp_statusordata), .kp_ack(kp_ack)
    );

    always #5 clk = ~clk;

    // Keypad: ready while its queue holds a code; an ack seen at a clock edge retires the head.
    assign kp_keyout = kp_statusordata ? {3'b000, kq_head != kq_tail} : kq[kq_head[3:0]];
    always @(posedge clk) if (kp_ack) begin
        kq_head <= kq_head + 1;
        ack_cnt <= ack_cnt + 1;
    end

    task automatic load_key(input logic [3:0] k);
        kq[kq_tail[3:0]] = k;
        kq_tail = kq_tail + 1;
    endtask

    task automatic wait_ack(input int budget, output bit got, output logic s2, output logic s1);
        got = 1'b0; s2 = 1'b0; s1 = kp_statusordata;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (kp_ack) begin got = 1'b1; break; end
            s2 = s1; s1 = kp_statusordata;
        end
    endtask

    task automatic pop_read(output logic [15:0] v);
        @(negedge clk); address = BASE; #1; v = rd_data;
        @(negedge clk); address = SADDR; #1;
    endtask

    task automatic test_reset();
        int polls;
        reset = 1'b1; address = SADDR; mem_wrt = 1'b0; cpu_wdata = 16'h0; #1;
        n_cmp++; if (kp_statusordata !== 1'b0) begin n_err++; $display("FAIL rst_sod: got %b want 0", kp_statusordata); end
        n_cmp++; if (kp_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", kp_ack); end
        n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL rst_status: got %h want 0000", rd_data); end
        n_cmp++; if (sel !== 1'b1) begin n_err++; $display("FAIL rst_sel_hit: got %b want 1", sel); end
        address = 12'h000; #1;
        n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL sel_miss: got %b want 0", sel); end
        repeat (3) @(negedge clk);
        reset = 1'b0; address = SADDR;
        polls = 0;
        repeat (40) begin @(negedge clk); #1; if (kp_statusordata) polls++; end
        n_cmp++; if (polls != 20) begin n_err++; $display("FAIL idle_poll_count: got %0d want 20", polls); end
        n_cmp++; if (ack_cnt != 0) begin n_err++; $display("FAIL idle_no_ack: got %0d want 0", ack_cnt); end
        n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL idle_status: got %h want 0000", rd_data); end
    endtask

    task automatic test_single_key();
        bit got; logic s2, s1; int gap; logic [15:0] v;
        load_key(4'h7);
        wait_ack(60, got, s2, s1);
        n_cmp++; if (!got) begin n_err++; $display("FAIL key7_ack_timeout: got none want pulse"); end
        n_cmp++; if ({s2, s1} !== 2'b10) begin n_err++; $display("FAIL key7_sod_seq: got %b want 10", {s2, s1}); end
        n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL key7_count_in_push: got %h want 0000", rd_data); end
        @(negedge clk); #1;
        n_cmp++; if (kp_ack !== 1'b0) begin n_err++; $display("FAIL key7_ack_width: got %b want 0", kp_ack); end
        n_cmp++; if (rd_data !== 16'h0005) begin n_err++; $display("FAIL key7_status: got %h want 0005", rd_data); end
        gap = 1;
        while (!kp_statusordata && gap < 40) begin @(negedge clk); #1; gap++; end
        n_cmp++; if (gap != 18) begin n_err++; $display("FAIL poll_gap: got %0d want 18", gap); end
        pop_read(v);
        n_cmp++; if (v !== 16'h0007) begin n_err++; $display("FAIL key7_data: got %h want 0007", v); end
        n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL key7_after_pop: got %h want 0000", rd_data); end
    endtask

    task automatic test_multi_cycle_read();
        bit g1, g2; logic s2, s1; logic [15:0] v;
        load_key(4'h1); load_key(4'h2);
        wait_ack(60, g1, s2, s1);
        wait_ack(60, g2, s2, s1);
        n_cmp++; if (!(g1 && g2)) begin n_err++; $display("FAIL mc_ack_timeout: got %b%b want 11", g1, g2); end
        @(negedge clk); #1;
        n_cmp++; if (rd_data !== 16'h0009) begin n_err++; $display("FAIL mc_status2: got %h want 0009", rd_data); end
        @(negedge clk); address = BASE; #1;
        n_cmp++; if (rd_data !== 16'h0001) begin n_err++; $display("FAIL mc_first: got %h want 0001", rd_data); end
        repeat (3) begin
            @(negedge clk); #1;
            n_cmp++; if (rd_data !== 16'h0002) begin n_err++; $display("FAIL mc_hold_head: got %h want 0002", rd_data); end
        end
        @(negedge clk); address = SADDR; #1;
        n_cmp++; if (rd_data !== 16'h0005) begin n_err++; $display("FAIL mc_single_pop: got %h want 0005", rd_data); end
        pop_read(v);
        n_cmp++; if (v !== 16'h0002) begin n_err++; $display("FAIL mc_second: got %h want 0002", v); end
    endtask

    task automatic test_fill_and_drain();
        bit got, all; logic s2, s1; logic [15:0] v; int acks0; int last;
        all = 1'b1;
        for (int i = 1; i <= 5; i++) load_key(4'(i));
        for (int i = 0; i < 4; i++) begin wait_ack(60, got, s2, s1); all &= got; end
        n_cmp++; if (!all) begin n_err++; $display("FAIL fill_ack_timeout: got none want 4 acks"); end
        @(negedge clk); #1;
        n_cmp++; if (rd_data !== 16'h0013) begin n_err++; $display("FAIL full_status: got %h want 0013", rd_data); end
        acks0 = ack_cnt;
        repeat (60) @(negedge clk);
        #1;
`ifdef KPFIFO_OVERFLOW_DROP_EN
        n_cmp++; if (ack_cnt != acks0 + 1) begin n_err++; $display("FAIL full_drop_ack: got %0d want %0d", ack_cnt, acks0 + 1); end
        n_cmp++; if (rd_data !== 16'h8013) begin n_err++; $display("FAIL ovf_status: got %h want 8013", rd_data); end
        last = 4;
`else
        n_cmp++; if (ack_cnt != acks0) begin n_err++; $display("FAIL full_stall_ack: got %0d want %0d", ack_cnt, acks0); end
        n_cmp++; if (rd_data !== 16'h0013) begin n_err++; $display("FAIL full_stall_status: got %h want 0013", rd_data); end
        last = 5;
`endif
        pop_read(v);
        n_cmp++; if (v !== 16'h0001) begin n_err++; $display("FAIL drain_1: got %h want 0001", v); end
`ifndef KPFIFO_OVERFLOW_DROP_EN
        wait_ack(60, got, s2, s1);
        n_cmp++; if (!got) begin n_err++; $display("FAIL pending_key_timeout: got none want pulse"); end
`endif
        for (int i = 2; i <= last; i++) begin
            pop_read(v);
            n_cmp++; if (v !== 16'(i)) begin n_err++; $display("FAIL drain_order: got %h want %h", v, 16'(i)); end
        end
`ifdef KPFIFO_OVERFLOW_DROP_EN
        n_cmp++; if (rd_data !== 16'h8000) begin n_err++; $display("FAIL ovf_sticky: got %h want 8000", rd_data); end
`else
        n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL drained: got %h want 0000", rd_data); end
`endif
        @(negedge clk); mem_wrt = 1'b1; cpu_wdata = 16'h0001;
        @(negedge clk); mem_wrt = 1'b0; cpu_wdata = 16'h0000; #1;
        n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL flush_clears_ovf: got %h want 0000", rd_data); end
    endtask

    task automatic test_push_pop_same_edge();
        bit got, all; logic s2, s1; logic [15:0] v;
        all = 1'b1;
        for (int i = 1; i <= FILL; i++) begin load_key(4'(i)); wait_ack(60, got, s2, s1); all &= got; end
        load_key(4'(FILL + 1));
        wait_ack(60, got, s2, s1); all &= got;
        n_cmp++; if (!all) begin n_err++; $display("FAIL pp_ack_timeout: got none want acks"); end
        address = BASE; #1;
        n_cmp++; if (rd_data !== 16'h0001) begin n_err++; $display("FAIL pp_head: got %h want 0001", rd_data); end
        @(negedge clk); address = SADDR; #1;
`ifdef KPFIFO_OVERFLOW_DROP_EN
        n_cmp++; if (rd_data !== 16'h0013) begin n_err++; $display("FAIL pp_count: got %h want 0013", rd_data); end
`else
        n_cmp++; if (rd_data !== 16'h000D) begin n_err++; $display("FAIL pp_count: got %h want 000d", rd_data); end
`endif
        for (int i = 2; i <= FILL + 1; i++) begin
            pop_read(v);
            n_cmp++; if (v !== 16'(i)) begin n_err++; $display("FAIL pp_order: got %h want %h", v, 16'(i)); end
        end
        n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL pp_empty: got %h want 0000", rd_data); end
    endtask

    task automatic test_flush_and_write_base();
        bit g1, g2; logic s2, s1;
        load_key(4'h6); load_key(4'h8);
        wait_ack(60, g1, s2, s1);
        wait_ack(60, g2, s2, s1);
        @(negedge clk); address = BASE; mem_wrt = 1'b1; cpu_wdata = 16'hFFFF;
        @(negedge clk); address = SADDR; mem_wrt = 1'b0; cpu_wdata = 16'h0000; #1;
        n_cmp++; if (rd_data !== 16'h0009) begin n_err++; $display("FAIL write_base_ignored: got %h want 0009", rd_data); end
        load_key(4'hA);
        wait_ack(60, g1, s2, s1);
        n_cmp++; if (!g1) begin n_err++; $display("FAIL fp_ack_timeout: got none want pulse"); end
        mem_wrt = 1'b1; cpu_wdata = 16'h0001;
        @(negedge clk); mem_wrt = 1'b0; cpu_wdata = 16'h0000; #1;
        n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL flush_beats_push: got %h want 0000", rd_data); end
    endtask

    task automatic test_reset_mid_push();
        bit got; logic s2, s1; logic [15:0] v; int acks0;
        load_key(4'h3);
        wait_ack(60, got, s2, s1);
        load_key(4'h9);
        wait_ack(60, got, s2, s1);
        n_cmp++; if (!got) begin n_err++; $display("FAIL rm_ack_timeout: got none want pulse"); end
        acks0 = ack_cnt;
        reset = 1'b1; #1;
        n_cmp++; if (kp_ack !== 1'b0) begin n_err++; $display("FAIL rm_ack_drop: got %b want 0", kp_ack); end
        n_cmp++; if (kp_statusordata !== 1'b0) begin n_err++; $display("FAIL rm_sod: got %b want 0", kp_statusordata); end
        n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL rm_count_clear: got %h want 0000", rd_data); end
        @(negedge clk); reset = 1'b0;
        wait_ack(60, got, s2, s1);
        n_cmp++; if (!got) begin n_err++; $display("FAIL rm_reread_timeout: got none want pulse"); end
        @(negedge clk); #1;
        n_cmp++; if (rd_data !== 16'h0005) begin n_err++; $display("FAIL rm_status: got %h want 0005", rd_data); end
        pop_read(v);
        n_cmp++; if (v !== 16'h0009) begin n_err++; $display("FAIL rm_code: got %h want 0009", v); end
        repeat (60) @(negedge clk);
        n_cmp++; if (ack_cnt != acks0 + 1) begin n_err++; $display("FAIL rm_pushed_once: got %0d want %0d", ack_cnt, acks0 + 1); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) kq[i] = 4'h0;
        test_reset();
        test_single_key();
        test_multi_cycle_read();
        test_fill_and_drain();
        test_push_pop_same_edge();
        test_flush_and_write_base();
        test_reset_mid_push();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
